// File: rtl/axis_fcs_check.sv
// Ethernet FCS checker/stripper for the receive path.
// Runs reflected CRC-32 over every frame byte (FCS included) and checks the
// residue on the last beat. The frame is forwarded one cycle later, with the
// trailing 4 FCS bytes optionally held back in a delay line and dropped.
// Bad frames are flagged on the output last beat, and good/bad frames are
// tallied in saturating counters.
module axis_fcs_check #(
    parameter int STRIP_FCS     = 1,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               saxis_tdata,
    input  logic                     saxis_tvalid,
    input  logic                     saxis_tuser,
    input  logic                     saxis_tlast,
    output logic [7:0]               maxis_tdata,
    output logic                     maxis_tvalid,
    output logic                     maxis_tuser,
    output logic                     maxis_tlast,
    output logic                     frame_done,
    output logic                     frame_error,
    output logic [COUNTER_WIDTH-1:0] ok_count,
    output logic [COUNTER_WIDTH-1:0] bad_count
);
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    // One byte of reflected CRC-32, processed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        return c;
    endfunction

    state_t                   state_q, state_d;
    logic [2:0]               fill_q, fill_d;
    logic [3:0][7:0]          dly_q;          // [0] newest, [3] oldest
    logic                     shift_en;
    logic [31:0]              crc_q, crc_next;
    logic                     frame_bad;
    logic [7:0]               data_q, data_d;
    logic                     vld_q, vld_d;
    logic                     last_q, last_d;
    logic                     user_q, user_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [COUNTER_WIDTH-1:0] ok_q, bad_q;

    // The residue check uses the CRC including the current (tlast) byte.
    assign crc_next  = crc32_byte(crc_q, saxis_tdata);
    assign frame_bad = (crc_next != RESIDUE) || saxis_tuser;

    // CRC register: advance on every beat, restart after the last byte.
    always_ff @(posedge clock) begin
        if (reset)
            crc_q <= INIT;
        else if (saxis_tvalid)
            crc_q <= saxis_tlast ? INIT : crc_next;
    end

    // Next-state and output-beat decode for both strip and pass-through modes.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        shift_en = 1'b0;
        vld_d    = 1'b0;
        data_d   = data_q;
        last_d   = 1'b0;
        user_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (saxis_tvalid) begin
            if (STRIP_FCS != 0) begin
                if (saxis_tlast) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    fill_d  = 3'd0;
                    if (state_q == STREAM) begin
                        // Oldest held byte is the final payload byte.
                        vld_d  = 1'b1;
                        data_d = dly_q[3];
                        last_d = 1'b1;
                        user_d = frame_bad;
                        err_d  = frame_bad;
                    end else begin
                        // Frame too short to hold an FCS plus payload.
                        err_d = 1'b1;
                    end
                end else begin
                    shift_en = 1'b1;
                    if (state_q == STREAM) begin
                        vld_d  = 1'b1;
                        data_d = dly_q[3];
                    end else begin
                        fill_d  = fill_q + 3'd1;
                        state_d = (fill_q == 3'd3) ? STREAM : FILL;
                    end
                end
            end else begin
                vld_d  = 1'b1;
                data_d = saxis_tdata;
                last_d = saxis_tlast;
                user_d = saxis_tlast && frame_bad;
                done_d = saxis_tlast;
                err_d  = saxis_tlast && frame_bad;
            end
        end
    end

    // FSM state, fill level and delay line.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            fill_q  <= 3'd0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            if (shift_en)
                dly_q <= {dly_q[2:0], saxis_tdata};
        end
    end

    // Registered output beat and per-frame status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= 8'h00;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            user_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            last_q <= last_d;
            user_q <= user_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Saturating frame counters, updated alongside the frame_done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            ok_q  <= '0;
            bad_q <= '0;
        end else if (done_d) begin
            if (err_d) begin
                if (bad_q != '1) bad_q <= bad_q + COUNTER_WIDTH'(1);
            end else begin
                if (ok_q != '1) ok_q <= ok_q + COUNTER_WIDTH'(1);
            end
        end
    end

    assign maxis_tdata  = data_q;
    assign maxis_tvalid = vld_q;
    assign maxis_tlast  = last_q;
    assign maxis_tuser  = user_q;
    assign frame_done   = done_q;
    assign frame_error  = err_q;
    assign ok_count     = ok_q;
    assign bad_count    = bad_q;
endmodule

// File: tb/tb_axis_fcs_check.sv
// Directed bench for axis_fcs_check (STRIP_FCS=1): known-FCS frames, corrupt
// FCS, short frames, back-to-back frames, rx error, mid-frame reset, plus a
// short run of generated frames against a scoreboard.
module tb_axis_fcs_check;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    saxis_tdata;
    logic          saxis_tvalid, saxis_tuser, saxis_tlast;
    logic [7:0]    maxis_tdata;
    logic          maxis_tvalid, maxis_tuser, maxis_tlast;
    logic          frame_done, frame_error;
    logic [CW-1:0] ok_count, bad_count;

    axis_fcs_check #(.STRIP_FCS(1), .COUNTER_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid),
        .saxis_tuser(saxis_tuser), .saxis_tlast(saxis_tlast),
        .maxis_tdata(maxis_tdata), .maxis_tvalid(maxis_tvalid),
        .maxis_tuser(maxis_tuser), .maxis_tlast(maxis_tlast),
        .frame_done(frame_done), .frame_error(frame_error),
        .ok_count(ok_count), .bad_count(bad_count)
    );

    always #5 clock = ~clock;

    logic [7:0] frm[$];
    logic [9:0] exq[$];
    logic [9:0] outq[$];
    int npass = 0, ntot = 0;
    int done_cnt = 0, err_cnt = 0, misalign = 0;
    int exp_ok = 0, exp_bad = 0, exp_done = 0, exp_err = 0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (maxis_tvalid) outq.push_back({maxis_tuser, maxis_tlast, maxis_tdata});
        if (frame_done) done_cnt++;
        if (frame_error) err_cnt++;
        if (frame_error && !frame_done) misalign++;
        if (maxis_tvalid && maxis_tlast && !frame_done) misalign++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic user);
        saxis_tdata  = d;
        saxis_tvalid = 1'b1;
        saxis_tlast  = last;
        saxis_tuser  = user;
        @(posedge clock); #1;
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        saxis_tuser  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    // Send frm back-to-back and record what the stripped output must be.
    task automatic send_frm(input logic user_last, input logic bad);
        int n;
        n = frm.size();
        for (int i = 0; i < n; i++)
            beat(frm[i], i == n - 1, user_last && (i == n - 1));
        for (int i = 0; i < n - 4; i++)
            exq.push_back({bad && (i == n - 5), i == n - 5, frm[i]});
        exp_done++;
        if (bad) begin exp_bad++; exp_err++; end
        else exp_ok++;
    endtask

    task automatic compare(input string tag);
        int n;
        idle(3);
        chk({tag, "_nbeats"}, outq.size(), exq.size());
        n = (outq.size() < exq.size()) ? outq.size() : exq.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_beat"}, {22'h0, outq[i]}, {22'h0, exq[i]});
        chk({tag, "_ok"}, ok_count, exp_ok);
        chk({tag, "_bad"}, bad_count, exp_bad);
        chk({tag, "_done"}, done_cnt, exp_done);
        chk({tag, "_err"}, err_cnt, exp_err);
        outq.delete();
        exq.delete();
    endtask

    task automatic load_a();
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
    endtask

    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = ((r[0] ^ b[i]) != 1'b0) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    initial begin
        int len, k, bt;
        logic [31:0] c;
        logic [7:0] tmp;
        logic corrupt, usr;
        logic [7:0] rem[$];

        reset = 1'b1;
        saxis_tdata = 8'h00; saxis_tvalid = 1'b0; saxis_tlast = 1'b0; saxis_tuser = 1'b0;
        idle(3);
        chk("rst_tvalid", maxis_tvalid, 0);
        chk("rst_tlast", maxis_tlast, 0);
        chk("rst_tuser", maxis_tuser, 0);
        chk("rst_tdata", maxis_tdata, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_ok", ok_count, 0);
        chk("rst_bad", bad_count, 0);
        reset = 1'b0;
        idle(2);

        // 1: good "123456789" frame
        load_a(); send_frm(1'b0, 1'b0); compare("t1_good");
        // 2: corrupted last FCS byte
        load_a(); frm[12] = 8'hCA; send_frm(1'b0, 1'b1); compare("t2_badfcs");
        // 3: 3-byte short frame, and 4-byte boundary case
        frm = '{8'hAA, 8'hBB, 8'hCC}; send_frm(1'b0, 1'b1); compare("t3_short3");
        frm = '{8'hDE, 8'hAD, 8'hBE, 8'hEF}; send_frm(1'b0, 1'b1); compare("t3_short4");
        // 4: two good frames with no gap
        load_a(); send_frm(1'b0, 1'b0);
        load_a(); send_frm(1'b0, 1'b0); compare("t4_b2b");
        // 5: good FCS but rx error flagged
        load_a(); send_frm(1'b1, 1'b1); compare("t5_rxerr");

        // Generated frames, 5..24 bytes, about half with a flipped FCS bit.
        for (int f = 0; f < 20; f++) begin
            len = (f == 0) ? 5 : $urandom_range(5, 24);
            frm.delete();
            c = 32'hFFFFFFFF;
            for (int i = 0; i < len - 4; i++) begin
                tmp = 8'($urandom_range(0, 255));
                frm.push_back(tmp);
                c = ref_crc(c, tmp);
            end
            c = ~c;
            for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
            corrupt = ($urandom_range(0, 1) == 1);
            usr = ($urandom_range(0, 7) == 0);
            if (corrupt) begin
                k = $urandom_range(0, 3);
                bt = $urandom_range(0, 7);
                tmp = frm[len - 1 - k];
                tmp[bt] = ~tmp[bt];
                frm[len - 1 - k] = tmp;
            end
            send_frm(usr, corrupt || usr);
            idle($urandom_range(0, 2));
        end
        compare("rand");

        // 6: reset after 6 bytes, then the remainder arrives as its own frame
        load_a();
        for (int i = 0; i < 6; i++) beat(frm[i], 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_rst_tvalid", maxis_tvalid, 0);
        chk("mid_rst_tlast", maxis_tlast, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_ok", ok_count, 0);
        chk("mid_rst_bad", bad_count, 0);
        reset = 1'b0;
        outq.delete();
        exq.delete();
        exp_ok = 0;
        exp_bad = 0;
        rem.delete();
        for (int i = 6; i < 13; i++) rem.push_back(frm[i]);
        frm = rem;
        send_frm(1'b0, 1'b1);
        load_a(); send_frm(1'b0, 1'b0);
        compare("t6_postrst");

        chk("pulse_align", misalign, 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
